// File: rtl/vec_execute_unit.sv
// vec_execute_unit -- execute stage of the vector alpha-composition pipeline.
//
// Resolves operand forwarding from FWD_PORTS later stages and then runs either
// a scalar ALU op on the low SCALAR_W bits or a lane-wise vector op across
// LANES lanes of LANE_W bits. MULHI (rounded high half of an unsigned
// multiply, used for alpha scaling) takes MUL_LAT cycles and stalls upstream.
// A {N,Z,C,V} flag register and a registered branch decision are also kept here.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, op        instruction present, opcode (0..8, others NOP)
//   vec_sel             1 = lane-wise vector op, 0 = scalar
//   cond_en, jmp_f      branch enable, condition (00 always, 01 EQ, 10 NE, 11 LT)
//   src_a/b, src_a/b_id register-file operands and their register ids
//   fwd_en/dest/data    forwarding sources, port 0 = youngest
//   stall               upstream must hold its current inputs
//   out_valid, result   registered ALU result
//   store_data          forwarded src_b, registered together with result
//   flags               {N,Z,C,V}
//   jmp_sel             one-cycle branch-taken pulse
module vec_execute_unit #(
    parameter int LANES     = 16,
    parameter int LANE_W    = 8,
    parameter int SCALAR_W  = 32,
    parameter int FWD_PORTS = 2,
    parameter int MUL_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [3:0]                    op,
    input  logic                          vec_sel,
    input  logic                          cond_en,
    input  logic [1:0]                    jmp_f,
    input  logic [LANES*LANE_W-1:0]       src_a,
    input  logic [LANES*LANE_W-1:0]       src_b,
    input  logic [3:0]                    src_a_id,
    input  logic [3:0]                    src_b_id,
    input  logic [FWD_PORTS-1:0]          fwd_en,
    input  logic [4*FWD_PORTS-1:0]        fwd_dest,
    input  logic [LANES*LANE_W*FWD_PORTS-1:0] fwd_data,
    output logic                          stall,
    output logic                          out_valid,
    output logic [LANES*LANE_W-1:0]       result,
    output logic [LANES*LANE_W-1:0]       store_data,
    output logic [3:0]                    flags,
    output logic                          jmp_sel
);

    localparam int VW  = LANES * LANE_W;
    localparam int SSH = $clog2(SCALAR_W);
    localparam int LSH = $clog2(LANE_W);
    localparam int CW  = $clog2(MUL_LAT) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_CMP   = 4'd7;
    localparam logic [3:0] OP_MULHI = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // Rounding constants 2^(W-1) for the MULHI high-half extraction.
    localparam logic [2*LANE_W-1:0]   L_RND = (2*LANE_W)'(1) << (LANE_W - 1);
    localparam logic [2*SCALAR_W-1:0] S_RND = (2*SCALAR_W)'(1) << (SCALAR_W - 1);

    logic [0:0]          state;
    logic [CW-1:0]       cnt;
    logic [VW-1:0]       mul_res_q;
    logic [VW-1:0]       mul_b_q;

    logic [VW-1:0]       a_op, b_op;
    logic                a_hit, b_hit;

    logic [SCALAR_W-1:0] sa, sb, s_res, s_mul;
    logic [SCALAR_W:0]   s_sum, s_dif;
    logic [2*SCALAR_W-1:0] s_p;
    logic [3:0]          s_flags;

    logic [LANE_W-1:0]   la, lb, lr;
    logic [2*LANE_W-1:0] lp;
    logic [VW-1:0]       v_res, v_mul;

    logic [VW-1:0]       mul_val, alu_res;
    logic                is_mul, is_alu, accept, take;

    // Forwarding: lowest-index matching port wins, whole VW operand replaced.
    always_comb begin
        a_op  = src_a;
        b_op  = src_b;
        a_hit = 1'b0;
        b_hit = 1'b0;
        for (int unsigned i = 0; i < FWD_PORTS; i++) begin
            if (!a_hit && fwd_en[i] && fwd_dest[4*i +: 4] == src_a_id) begin
                a_op  = fwd_data[VW*i +: VW];
                a_hit = 1'b1;
            end
            if (!b_hit && fwd_en[i] && fwd_dest[4*i +: 4] == src_b_id) begin
                b_op  = fwd_data[VW*i +: VW];
                b_hit = 1'b1;
            end
        end
    end

    // Scalar datapath on the low SCALAR_W bits.
    always_comb begin
        sa    = a_op[SCALAR_W-1:0];
        sb    = b_op[SCALAR_W-1:0];
        s_sum = {1'b0, sa} + {1'b0, sb};
        s_dif = {1'b0, sa} + {1'b0, ~sb} + (SCALAR_W+1)'(1);   // carry = no borrow
        s_p   = (2*SCALAR_W)'(sa) * (2*SCALAR_W)'(sb) + S_RND;
        s_mul = s_p[2*SCALAR_W-1:SCALAR_W];
        case (op)
            OP_ADD:  s_res = s_sum[SCALAR_W-1:0];
            OP_SUB:  s_res = s_dif[SCALAR_W-1:0];
            OP_AND:  s_res = sa & sb;
            OP_OR:   s_res = sa | sb;
            OP_XOR:  s_res = sa ^ sb;
            OP_SHL:  s_res = sa << sb[SSH-1:0];
            OP_SHR:  s_res = sa >> sb[SSH-1:0];
            default: s_res = '0;
        endcase
        if (op == OP_ADD)
            s_flags = {s_sum[SCALAR_W-1], s_sum[SCALAR_W-1:0] == '0, s_sum[SCALAR_W],
                       (sa[SCALAR_W-1] == sb[SCALAR_W-1]) && (s_sum[SCALAR_W-1] != sa[SCALAR_W-1])};
        else
            s_flags = {s_dif[SCALAR_W-1], s_dif[SCALAR_W-1:0] == '0, s_dif[SCALAR_W],
                       (sa[SCALAR_W-1] != sb[SCALAR_W-1]) && (s_dif[SCALAR_W-1] != sa[SCALAR_W-1])};
    end

    // Vector datapath: every lane computed in isolation, so no carries cross.
    always_comb begin
        v_res = '0;
        v_mul = '0;
        la    = '0;
        lb    = '0;
        lr    = '0;
        lp    = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            la = a_op[l*LANE_W +: LANE_W];
            lb = b_op[l*LANE_W +: LANE_W];
            case (op)
                OP_ADD:  lr = la + lb;
                OP_SUB:  lr = la - lb;
                OP_AND:  lr = la & lb;
                OP_OR:   lr = la | lb;
                OP_XOR:  lr = la ^ lb;
                OP_SHL:  lr = la << lb[LSH-1:0];
                OP_SHR:  lr = la >> lb[LSH-1:0];
                default: lr = '0;
            endcase
            lp = (2*LANE_W)'(la) * (2*LANE_W)'(lb) + L_RND;
            v_res[l*LANE_W +: LANE_W] = lr;
            v_mul[l*LANE_W +: LANE_W] = lp[2*LANE_W-1:LANE_W];
        end
    end

    always_comb begin
        is_mul  = (op == OP_MULHI);
        is_alu  = (op <= OP_MULHI);
        mul_val = vec_sel ? v_mul : VW'(s_mul);
        alu_res = is_mul ? mul_val : (vec_sel ? v_res : VW'(s_res));
        // A MULHI is consumed on the same cycle it raises stall; stall then
        // tells upstream to hold the instruction that follows it.
        accept  = in_valid && (state == S_IDLE);
        stall   = (state == S_BUSY) || (MUL_LAT > 1 && accept && is_mul);
        case (jmp_f)
            2'b00:   take = 1'b1;
            2'b01:   take = flags[2];
            2'b10:   take = !flags[2];
            default: take = flags[3] ^ flags[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mul_res_q  <= '0;
            mul_b_q    <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            store_data <= '0;
            flags      <= '0;
            jmp_sel    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            jmp_sel   <= 1'b0;
            if (state == S_BUSY) begin
                if (cnt == CW'(1)) begin
                    state      <= S_IDLE;
                    out_valid  <= 1'b1;
                    result     <= mul_res_q;
                    store_data <= mul_b_q;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else if (accept) begin
                jmp_sel <= cond_en && take;
                if (is_mul && MUL_LAT > 1) begin
                    state     <= S_BUSY;
                    cnt       <= CW'(MUL_LAT - 1);
                    mul_res_q <= mul_val;
                    mul_b_q   <= b_op;
                end else if (is_alu) begin
                    out_valid  <= 1'b1;
                    result     <= alu_res;
                    store_data <= b_op;
                end
                if (!vec_sel && (op == OP_ADD || op == OP_SUB || op == OP_CMP))
                    flags <= s_flags;
            end
        end
    end

endmodule

// File: tb/tb_vec_execute_unit.sv
module tb_vec_execute_unit;

    localparam int VW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [3:0]    op;
    logic          vec_sel;
    logic          cond_en;
    logic [1:0]    jmp_f;
    logic [VW-1:0] src_a, src_b;
    logic [3:0]    src_a_id, src_b_id;
    logic [1:0]    fwd_en;
    logic [7:0]    fwd_dest;
    logic [2*VW-1:0] fwd_data;
    logic          stall, out_valid, jmp_sel;
    logic [VW-1:0] result, store_data;
    logic [3:0]    flags;

    int n_vec = 0;
    int n_bad = 0;

    vec_execute_unit #(
        .LANES(16), .LANE_W(8), .SCALAR_W(32), .FWD_PORTS(2), .MUL_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .vec_sel(vec_sel),
        .cond_en(cond_en), .jmp_f(jmp_f), .src_a(src_a), .src_b(src_b),
        .src_a_id(src_a_id), .src_b_id(src_b_id), .fwd_en(fwd_en),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data), .stall(stall),
        .out_valid(out_valid), .result(result), .store_data(store_data),
        .flags(flags), .jmp_sel(jmp_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; op = 4'd15; vec_sel = 1'b0; cond_en = 1'b0; jmp_f = 2'b00;
        src_a = '0; src_b = '0; src_a_id = 4'd0; src_b_id = 4'd0;
        fwd_en = '0; fwd_dest = '0; fwd_data = '0;
    endtask

    task automatic drive(input logic [3:0] o, input logic v, input logic [VW-1:0] a, input logic [VW-1:0] b);
        idle();
        in_valid = 1'b1; op = o; vec_sel = v; src_a = a; src_b = b;
        src_a_id = 4'd1; src_b_id = 4'd2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_result", result, 0);
        check("rst_store", store_data, 0);
        check("rst_flags", flags, 0);
        check("rst_jmp", jmp_sel, 0);
        rst = 1'b0;

        // make flags nonzero, then reset during a MULHI
        drive(4'd0, 1'b0, 128'hFFFF_FFFF, 128'h1);
        step();
        check("add_wrap_res", result, 0);
        check("add_wrap_flags", flags, 4'b0110);
        drive(4'd8, 1'b1, {16{8'hFF}}, {16{8'h80}});
        #1 check("mrst_stall0", stall, 1);
        step();
        idle();
        rst = 1'b1;
        #1 check("mrst_stall1", stall, 1);
        step();
        rst = 1'b0;
        check("mrst_stall", stall, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_flags", flags, 0);
        check("mrst_result", result, 0);
        step();
        check("mrst_late1", out_valid, 0);
        step();
        check("mrst_late2", out_valid, 0);
        check("mrst_late_res", result, 0);

        // scalar SUB 5-5 then branches on its flags
        drive(4'd1, 1'b0, 128'h5, 128'h5);
        step();
        check("sub_res", result, 0);
        check("sub_valid", out_valid, 1);
        check("sub_flags", flags, 4'b0110);
        check("sub_store", store_data, 128'h5);
        drive(4'd15, 1'b0, '0, '0);
        cond_en = 1'b1; jmp_f = 2'b01;
        step();
        check("beq_jmp", jmp_sel, 1);
        check("nop_valid", out_valid, 0);
        drive(4'd15, 1'b0, '0, '0);
        cond_en = 1'b1; jmp_f = 2'b10;
        step();
        check("bne_jmp", jmp_sel, 0);

        // scalar signed overflow, upper operand bits ignored
        drive(4'd0, 1'b0, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h7FFF_FFFF}, 128'h1);
        step();
        check("ovf_res", result, 128'h8000_0000);
        check("ovf_flags", flags, 4'b1001);

        // vector ADD, lane carries dropped; branch LT sees N^V=0
        drive(4'd0, 1'b1, {8'hFF, 104'h0, 8'h10, 8'hFF}, {8'h01, 104'h0, 8'h20, 8'h01});
        cond_en = 1'b1; jmp_f = 2'b11;
        step();
        check("vadd_res", result, {8'h00, 104'h0, 8'h30, 8'h00});
        check("vadd_flags", flags, 4'b1001);
        check("vadd_jmp", jmp_sel, 0);

        // forwarding priority
        drive(4'd3, 1'b1, {16{8'h11}}, '0);
        src_a_id = 4'd3; src_b_id = 4'd5;
        fwd_en = 2'b11; fwd_dest = {4'd3, 4'd3};
        fwd_data = {{16{8'hBB}}, {16{8'hAA}}};
        step();
        check("fwd_port0", result, {16{8'hAA}});
        check("fwd_store_rf", store_data, 0);
        drive(4'd3, 1'b1, {16{8'h11}}, '0);
        src_a_id = 4'd3; src_b_id = 4'd3;
        fwd_en = 2'b11; fwd_dest = {4'd3, 4'd7};
        fwd_data = {{16{8'hBB}}, {16{8'hAA}}};
        step();
        check("fwd_port1", result, {16{8'hBB}});
        check("fwd_store", store_data, {16{8'hBB}});

        // vector MULHI with a held follower (SHR 0x80 by 9 -> amount 1)
        drive(4'd8, 1'b1, {16{8'hFF}}, {16{8'h80}});
        #1 check("mul_stall0", stall, 1);
        step();
        drive(4'd6, 1'b1, {16{8'h80}}, {16{8'h09}});
        #1 check("mul_stall1", stall, 1);
        check("mul_valid1", out_valid, 0);
        step();
        check("mul_stall2", stall, 0);
        check("mul_valid2", out_valid, 1);
        check("mul_res", result, {16{8'h80}});
        check("mul_store", store_data, {16{8'h80}});
        step();
        check("vshr_res", result, {16{8'h40}});
        check("vshr_valid", out_valid, 1);

        // scalar SHL 1 by 31 (b=0x3F, low 5 bits used)
        drive(4'd5, 1'b0, 128'h1, 128'h3F);
        step();
        check("shl_res", result, 128'h8000_0000);
        check("shl_flags", flags, 4'b1001);
        idle();
        step();
        check("idle_valid", out_valid, 0);
        check("idle_hold", result, 128'h8000_0000);

        // CMP 3-5: result 0, N=1 C=0; LT branch next
        drive(4'd7, 1'b0, 128'h3, 128'h5);
        step();
        check("cmp_res", result, 0);
        check("cmp_valid", out_valid, 1);
        check("cmp_flags", flags, 4'b1000);
        drive(4'd15, 1'b0, '0, '0);
        cond_en = 1'b1; jmp_f = 2'b11;
        step();
        check("blt_jmp", jmp_sel, 1);
        idle();
        step();
        check("jmp_pulse", jmp_sel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
